// File: rtl/uart_mmio_peripheral.sv
// Memory-mapped 8N1 UART for the MEM-stage peripheral bus: TXD/RXD/CON registers, combinational reads, level IRQ.
// Define UART_RX_FIFO_EN to replace the single receive holding register with a 4-entry receive FIFO.
module uart_mmio_peripheral #(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned BAUD      = 9600,
  parameter logic [31:0] BASE_ADDR = 32'h4000_0018,
  parameter int unsigned OSR       = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_address,
  input  logic        i_control_read,
  input  logic        i_control_write,
  input  logic [31:0] i_control_write_data,
  output logic [31:0] o_control_read_data,
  input  logic        i_rx,
  output logic        o_tx,
  output logic        o_irq
);

  localparam int unsigned DIV_RAW = CLK_FREQ / (BAUD * OSR);
  localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int          CNT_W   = $clog2(OSR + 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(OSR - 1);
  localparam logic [CNT_W-1:0] MID_LAST = CNT_W'(OSR / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic sel_txd, sel_rxd, sel_con;
  logic txd_wr, con_wr, con_rd, rxd_rd;
  logic tx_irq_en, rx_irq_en, tx_done, rx_overrun;
  logic rx_valid, rx_pop, rx_overflow;
  logic [7:0] rx_head;
  logic unused_wdata;

  assign sel_txd = (i_address == BASE_ADDR);
  assign sel_rxd = (i_address == BASE_ADDR + 32'd4);
  assign sel_con = (i_address == BASE_ADDR + 32'd8);
  assign txd_wr  = i_control_write & sel_txd;
  assign con_wr  = i_control_write & sel_con;
  assign con_rd  = i_control_read & sel_con;
  assign rxd_rd  = i_control_read & sel_rxd;
  assign unused_wdata = ^i_control_write_data[31:8];

  logic [31:0] div_cnt;
  logic        tick;

  assign tick = (div_cnt == DIV - 1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 32'd1;
  end

  tx_state_t        tx_state, tx_state_next;
  logic [CNT_W-1:0] tx_cnt;
  logic [2:0]       tx_idx;
  logic [7:0]       tx_shift;
  logic             tx_bit_end, tx_load, tx_finish, tx_line_next, tx_busy;

  assign tx_bit_end = tick && (tx_cnt == BIT_LAST);
  assign tx_busy    = (tx_state != TX_IDLE);

  // o_tx is registered from the next line level so it changes on the same edge as the state.
  always_comb begin
    tx_state_next = tx_state;
    tx_line_next  = 1'b1;
    tx_load       = 1'b0;
    tx_finish     = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (txd_wr) begin
          tx_state_next = TX_START;
          tx_load       = 1'b1;
          tx_line_next  = 1'b0;
        end
      end
      TX_START: begin
        tx_line_next = 1'b0;
        if (tx_bit_end) begin
          tx_state_next = TX_DATA;
          tx_line_next  = tx_shift[0];
        end
      end
      TX_DATA: begin
        tx_line_next = tx_shift[0];
        if (tx_bit_end) begin
          if (tx_idx == 3'd7) begin
            tx_state_next = TX_STOP;
            tx_line_next  = 1'b1;
          end else begin
            tx_line_next = tx_shift[1];
          end
        end
      end
      TX_STOP: begin
        if (tx_bit_end) begin
          tx_state_next = TX_IDLE;
          tx_finish     = 1'b1;
        end
      end
      default: tx_state_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
      o_tx     <= 1'b1;
    end else begin
      tx_state <= tx_state_next;
      o_tx     <= tx_line_next;
      if (tx_load)
        tx_shift <= i_control_write_data[7:0];
      else if (tx_state == TX_DATA && tx_bit_end)
        tx_shift <= {1'b0, tx_shift[7:1]};
      if (tx_state == TX_IDLE || tx_bit_end) tx_cnt <= '0;
      else if (tick)                         tx_cnt <= tx_cnt + CNT_W'(1);
      if (tx_state == TX_START)                   tx_idx <= '0;
      else if (tx_state == TX_DATA && tx_bit_end) tx_idx <= tx_idx + 3'd1;
    end
  end

  logic [1:0]       rx_sync;
  logic             rx_prev, rx_bit, rx_fall;
  rx_state_t        rx_state, rx_state_next;
  logic [CNT_W-1:0] rx_cnt;
  logic [2:0]       rx_idx;
  logic [7:0]       rx_shift;
  logic             rx_cnt_clr, rx_shift_en, rx_deliver;

  assign rx_bit  = rx_sync[1];
  assign rx_fall = rx_prev & ~rx_bit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_sync <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      rx_sync <= {rx_sync[0], i_rx};
      rx_prev <= rx_bit;
    end
  end

  // Start is checked half a bit in; every later sample lands a whole bit after the previous one.
  always_comb begin
    rx_state_next = rx_state;
    rx_cnt_clr    = 1'b0;
    rx_shift_en   = 1'b0;
    rx_deliver    = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (rx_fall) begin
          rx_state_next = RX_START;
          rx_cnt_clr    = 1'b1;
        end
      end
      RX_START: begin
        if (tick && rx_cnt == MID_LAST) begin
          rx_cnt_clr    = 1'b1;
          rx_state_next = rx_bit ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (tick && rx_cnt == BIT_LAST) begin
          rx_cnt_clr  = 1'b1;
          rx_shift_en = 1'b1;
          if (rx_idx == 3'd7) rx_state_next = RX_STOP;
        end
      end
      RX_STOP: begin
        if (tick && rx_cnt == BIT_LAST) begin
          rx_state_next = RX_IDLE;
          rx_deliver    = rx_bit;
        end
      end
      default: rx_state_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_shift <= '0;
    end else begin
      rx_state <= rx_state_next;
      if (rx_cnt_clr) rx_cnt <= '0;
      else if (tick)  rx_cnt <= rx_cnt + CNT_W'(1);
      if (rx_state == RX_START) rx_idx <= '0;
      else if (rx_shift_en)     rx_idx <= rx_idx + 3'd1;
      if (rx_shift_en) rx_shift <= {rx_bit, rx_shift[7:1]};
    end
  end

  assign rx_pop = rxd_rd & rx_valid;

`ifdef UART_RX_FIFO_EN
  logic [7:0] fifo_mem [4];
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] fifo_count;
  logic       fifo_push;

  // A pop on the delivery edge frees the slot, so a full FIFO still accepts the byte.
  assign rx_overflow = rx_deliver & (fifo_count == 3'd4) & ~rx_pop;
  assign fifo_push   = rx_deliver & ~rx_overflow;
  assign rx_valid    = (fifo_count != 3'd0);
  assign rx_head     = fifo_mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (fifo_push) wr_ptr <= wr_ptr + 2'd1;
      if (rx_pop)    rd_ptr <= rd_ptr + 2'd1;
      case ({fifo_push, rx_pop})
        2'b10:   fifo_count <= fifo_count + 3'd1;
        2'b01:   fifo_count <= fifo_count - 3'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_push) fifo_mem[wr_ptr] <= rx_shift;
  end
`else
  logic [7:0] hold_data;
  logic       hold_valid;

  assign rx_overflow = rx_deliver & hold_valid & ~rx_pop;
  assign rx_valid    = hold_valid;
  assign rx_head     = hold_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_data  <= '0;
      hold_valid <= 1'b0;
    end else if (rx_deliver && !rx_overflow) begin
      hold_data  <= rx_shift;
      hold_valid <= 1'b1;
    end else if (rx_pop) begin
      hold_valid <= 1'b0;
    end
  end
`endif

  // Sticky flags: a new event on the clearing read's edge wins, since the read returned the old value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_irq_en  <= 1'b0;
      rx_irq_en  <= 1'b0;
      tx_done    <= 1'b0;
      rx_overrun <= 1'b0;
      o_irq      <= 1'b0;
    end else begin
      if (con_wr) begin
        tx_irq_en <= i_control_write_data[0];
        rx_irq_en <= i_control_write_data[1];
      end
      if (tx_finish)   tx_done <= 1'b1;
      else if (con_rd) tx_done <= 1'b0;
      if (rx_overflow) rx_overrun <= 1'b1;
      else if (con_rd) rx_overrun <= 1'b0;
      o_irq <= (tx_irq_en & tx_done) | (rx_irq_en & rx_valid);
    end
  end

  always_comb begin
    o_control_read_data = '0;
    if (i_control_read) begin
      if (sel_con)
        o_control_read_data = {26'd0, rx_overrun, tx_busy, rx_valid, tx_done, rx_irq_en, tx_irq_en};
      else if (sel_rxd && rx_valid)
        o_control_read_data = {24'd0, rx_head};
    end
  end

endmodule

// File: tb/tb_uart_mmio_peripheral.sv
// Self-checking bench for uart_mmio_peripheral: register vector table, directed frame sequences, randomized traffic vs a queue model.
module tb_uart_mmio_peripheral;

  localparam int unsigned CLK_FREQ = 1_600_000;
  localparam int unsigned BAUD     = 100_000;
  localparam logic [31:0] TXD_A    = 32'h4000_0018;
  localparam logic [31:0] RXD_A    = 32'h4000_001C;
  localparam logic [31:0] CON_A    = 32'h4000_0020;
  localparam int          BIT_CLK  = 16;
`ifdef UART_RX_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] address = '0;
  logic        rd_en = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] wr_data = '0;
  logic [31:0] read_data;
  logic        rx_line = 1'b1;
  logic        tx_line;
  logic        irq;

  uart_mmio_peripheral #(
    .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .BASE_ADDR(TXD_A), .OSR(16)
  ) dut (
    .clk(clk), .reset(reset), .i_address(address), .i_control_read(rd_en),
    .i_control_write(wr_en), .i_control_write_data(wr_data),
    .o_control_read_data(read_data), .i_rx(rx_line), .o_tx(tx_line), .o_irq(irq)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: received bytes in arrival order plus the flag bits software sees.
  logic [7:0] rx_q[$];
  logic m_tx_done = 1'b0, m_overrun = 1'b0, m_tx_en = 1'b0, m_rx_en = 1'b0;

  typedef struct {
    logic [31:0] addr;
    logic        rd;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[13];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic checkWave(input string name, input logic [159:0] actual, input logic [159:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic rd, input logic wr,
                               input logic [31:0] wdata, output logic [31:0] rdata);
    @(negedge clk);
    address = addr;
    rd_en   = rd;
    wr_en   = wr;
    wr_data = wdata;
    #1 rdata = read_data;
    @(posedge clk);
    #1;
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    address = '0;
    wr_data = '0;
  endtask

  task automatic busWrite(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] dummy;
    applyStimulus(addr, 1'b0, 1'b1, data, dummy);
    if (addr == CON_A) begin
      m_tx_en = data[0];
      m_rx_en = data[1];
    end
  endtask

  function automatic logic [31:0] conModel();
    return {26'd0, m_overrun, 1'b0, rx_q.size() != 0, m_tx_done, m_rx_en, m_tx_en};
  endfunction

  task automatic readCon(input string name);
    logic [31:0] d;
    applyStimulus(CON_A, 1'b1, 1'b0, '0, d);
    checkOutput(name, d, conModel());
    m_tx_done = 1'b0;
    m_overrun = 1'b0;
  endtask

  task automatic readRxd(input string name);
    logic [31:0] d, e;
    e = (rx_q.size() != 0) ? {24'd0, rx_q[0]} : 32'd0;
    applyStimulus(RXD_A, 1'b1, 1'b0, '0, d);
    checkOutput(name, d, e);
    if (rx_q.size() != 0) void'(rx_q.pop_front());
  endtask

  function automatic void modelDeliver(input logic [7:0] b);
    if (rx_q.size() < DEPTH) rx_q.push_back(b);
    else m_overrun = 1'b1;
  endfunction

  // One 8N1 frame on i_rx, 16 clocks per bit, followed by idle line.
  task automatic sendRxByte(input logic [7:0] data, input logic stop);
    logic [9:0] frame;
    frame = {stop, data, 1'b0};
    for (int b = 0; b < 10; b++) begin
      @(negedge clk);
      rx_line = frame[b];
      repeat (BIT_CLK - 1) @(negedge clk);
    end
    @(negedge clk);
    rx_line = 1'b1;
    repeat (BIT_CLK + 4) @(negedge clk);
  endtask

  // Expected o_tx level for each of the 160 clocks following the TXD write edge.
  function automatic logic [159:0] frameWave(input logic [7:0] b);
    logic [159:0] w;
    int slot;
    for (int i = 0; i < 160; i++) begin
      slot = i / BIT_CLK;
      if (slot == 0)      w[i] = 1'b0;
      else if (slot <= 8) w[i] = b[slot-1];
      else                w[i] = 1'b1;
    end
    return w;
  endfunction

  task automatic captureTx(output logic [159:0] wave);
    for (int i = 0; i < 160; i++) begin
      @(negedge clk);
      #1 wave[i] = tx_line;
    end
  endtask

  task automatic resetModel();
    rx_q.delete();
    m_tx_done = 1'b0;
    m_overrun = 1'b0;
    m_tx_en   = 1'b0;
    m_rx_en   = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0]  d;
    logic [159:0] wave, busy_wave, ones;
    logic         irq_early, idle_ok;
    logic [7:0]   b;
    logic         stop;

    vecs[0]  = '{CON_A,          1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0};
    vecs[1]  = '{CON_A,          1'b1, 1'b0, 32'h0,         32'h3};
    vecs[2]  = '{CON_A,          1'b1, 1'b1, 32'h1,         32'h3};
    vecs[3]  = '{CON_A,          1'b1, 1'b0, 32'h0,         32'h1};
    vecs[4]  = '{CON_A,          1'b0, 1'b0, 32'h0,         32'h0};
    vecs[5]  = '{CON_A,          1'b1, 1'b1, 32'h3C,        32'h1};
    vecs[6]  = '{CON_A,          1'b1, 1'b0, 32'h0,         32'h0};
    vecs[7]  = '{TXD_A,          1'b1, 1'b0, 32'h0,         32'h0};
    vecs[8]  = '{RXD_A,          1'b1, 1'b0, 32'h0,         32'h0};
    vecs[9]  = '{TXD_A + 32'd12, 1'b0, 1'b1, 32'hFF,        32'h0};
    vecs[10] = '{TXD_A + 32'd12, 1'b1, 1'b0, 32'h0,         32'h0};
    vecs[11] = '{TXD_A - 32'd4,  1'b1, 1'b0, 32'h0,         32'h0};
    vecs[12] = '{CON_A,          1'b1, 1'b0, 32'h0,         32'h0};
    ones = '1;

    repeat (3) @(negedge clk);
    address = CON_A;
    rd_en   = 1'b1;
    #1;
    checkOutput("reset_tx", tx_line, 1);
    checkOutput("reset_irq", irq, 0);
    checkOutput("reset_rdata", read_data, 0);
    rd_en = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].addr, vecs[i].rd, vecs[i].wr, vecs[i].wdata, d);
      checkOutput($sformatf("vec%0d", i), d, vecs[i].exp);
    end
    repeat (3) @(negedge clk);
    checkOutput("no_frame_unmapped", tx_line, 1);

    $display("[TB] TX frame 0xA5");
    busWrite(TXD_A, 32'h0000_00A5);
    for (int i = 0; i < 160; i++) begin
      @(negedge clk);
      address = CON_A;
      rd_en   = 1'b1;
      #1;
      wave[i]      = tx_line;
      busy_wave[i] = read_data[4];
      if (i == 159) begin
        rd_en   = 1'b0;
        address = '0;
      end
    end
    checkWave("tx_wave_a5", wave, frameWave(8'hA5));
    checkWave("tx_busy_a5", busy_wave, ones);
    m_tx_done = 1'b1;
    readCon("con_after_tx");

    $display("[TB] RX byte 0x3C");
    sendRxByte(8'h3C, 1'b1);
    modelDeliver(8'h3C);
    readCon("con_rx_valid");
    readRxd("rxd_3c");
    readCon("con_after_pop");

    $display("[TB] RX glitch and frame error");
    @(negedge clk);
    rx_line = 1'b0;
    repeat (6) @(negedge clk);
    rx_line = 1'b1;
    repeat (40) @(negedge clk);
    readCon("con_after_glitch");
    sendRxByte(8'h81, 1'b0);
    readCon("con_after_frame_err");
    sendRxByte(8'h5E, 1'b1);
    modelDeliver(8'h5E);
    readRxd("rxd_after_glitch");

    $display("[TB] RX overrun with depth %0d", DEPTH);
    for (int i = 0; i <= DEPTH; i++) begin
      b = 8'((i + 1) * 8'h11);
      sendRxByte(b, 1'b1);
      modelDeliver(b);
    end
    readCon("con_overrun");
    for (int i = 0; i <= DEPTH; i++) readRxd($sformatf("rxd_drain%0d", i));
    readCon("con_drained");

    $display("[TB] TX interrupt and busy write");
    busWrite(CON_A, 32'h3);
    busWrite(TXD_A, 32'h0000_00C6);
    irq_early = 1'b0;
    idle_ok   = 1'b1;
    for (int i = 0; i < 170; i++) begin
      @(negedge clk);
      if (i == 40) begin
        address = TXD_A;
        wr_en   = 1'b1;
        wr_data = 32'h0000_005A;
      end else if (i == 41) begin
        wr_en   = 1'b0;
        address = '0;
        wr_data = '0;
      end
      #1;
      if (i < 160) begin
        wave[i]   = tx_line;
        irq_early = irq_early | irq;
      end else if (i == 160) begin
        checkOutput("irq_not_yet", irq, 0);
      end else if (i == 161) begin
        checkOutput("irq_rise", irq, 1);
      end else begin
        idle_ok = idle_ok & tx_line;
      end
    end
    checkWave("tx_wave_c6", wave, frameWave(8'hC6));
    checkOutput("irq_early", irq_early, 0);
    checkOutput("tx_idle_after", idle_ok, 1);
    m_tx_done = 1'b1;
    readCon("con_irq");
    repeat (2) @(negedge clk);
    #1 checkOutput("irq_drop", irq, 0);

    $display("[TB] reset mid-frame");
    busWrite(TXD_A, 32'h0000_000F);
    repeat (89) @(negedge clk);
    #1 checkOutput("tx_bit4_low", tx_line, 0);
    reset = 1'b0;
    #1 checkOutput("tx_abort", tx_line, 1);
    address = CON_A;
    rd_en   = 1'b1;
    #1 checkOutput("con_in_reset", read_data, 0);
    rd_en   = 1'b0;
    address = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    resetModel();
    repeat (20) @(negedge clk);
    #1 checkOutput("tx_idle_post_reset", tx_line, 1);
    readCon("con_post_reset");
    sendRxByte(8'hC3, 1'b1);
    modelDeliver(8'hC3);
    readRxd("rxd_post_reset");

    $display("[TB] randomized traffic");
    for (int n = 0; n < 20; n++) begin
      case ($urandom_range(0, 4))
        0: begin
          b    = 8'($urandom);
          stop = ($urandom_range(0, 7) != 0);
          sendRxByte(b, stop);
          if (stop) modelDeliver(b);
        end
        1: readRxd($sformatf("rand%0d_rxd", n));
        2: readCon($sformatf("rand%0d_con", n));
        3: begin
          b = 8'($urandom);
          busWrite(TXD_A, {24'($urandom), b});
          captureTx(wave);
          checkWave($sformatf("rand%0d_tx", n), wave, frameWave(b));
          repeat (3) @(negedge clk);
          m_tx_done = 1'b1;
        end
        default: busWrite(CON_A, 32'($urandom));
      endcase
      repeat (2) @(negedge clk);
      #1 checkOutput($sformatf("rand%0d_irq", n), irq,
                     (m_tx_en & m_tx_done) | (m_rx_en & (rx_q.size() != 0)));
    end
    readCon("final_con");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
